// File: rtl/shift_unit_seq_pkg.sv
// Shared definitions for the sequential shift unit: widths, opcodes and FSM state encodings.
package shift_unit_seq_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  // Number of binary-weighted stages (16, 8, 4, 2, 1)
  localparam int unsigned NUM_STAGES = SHAMT_W;

  // Index of the first (largest) stage loaded at capture
  localparam logic [2:0] K_FIRST = 3'(NUM_STAGES - 1);

  localparam logic OP_SLL = 1'b0;
  localparam logic OP_SRA = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_unit_seq_shift_stage.sv
// One variable-amount shift stage: shifts by 2^k when enabled, otherwise passes data through.
module shift_stage
  import shift_unit_seq_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic              op_i,
  input  logic [2:0]        k_i,
  input  logic              enable_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0] amt;

  // Decode stage weight and apply the selected shift
  always_comb begin
    amt    = 8'd1 << k_i;
    data_o = data_i;
    if (enable_i) begin
      if (op_i == OP_SRA) begin
        // Sign bit of the working value is the captured operand bit 31 at every stage
        data_o = unsigned'($signed(data_i) >>> amt);
      end else begin
        data_o = data_i << amt;
      end
    end
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Sequential barrel shifter: captures an operand, applies stages 16/8/4/2/1 over five cycles,
// then presents a registered result with a one-cycle ready pulse.
module shift_unit_seq
  import shift_unit_seq_pkg::*;
(
  input  logic               clock,
  input  logic               resetn,
  input  logic               ctrl_shift,
  input  logic               ctrl_op,
  input  logic [DATA_W-1:0]  data_operandA,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt,
  output logic [DATA_W-1:0]  data_result,
  output logic               data_resultRDY,
  output logic               busy
);

  state_e             state_q;
  logic [2:0]         k_q;
  logic [DATA_W-1:0]  work_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic               op_q;
  logic [DATA_W-1:0]  result_q;
  logic               rdy_q;
  logic               busy_q;

  logic               stage_en;
  logic [DATA_W-1:0]  stage_out;

  // Current stage is enabled by the matching bit of the captured shift amount
  always_comb begin
    stage_en = shamt_q[k_q];
  end

  shift_stage u_stage (
    .data_i   (work_q),
    .op_i     (op_q),
    .k_i      (k_q),
    .enable_i (stage_en),
    .data_o   (stage_out)
  );

  // FSM, stage counter, capture registers and result register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      k_q      <= 3'd0;
      work_q   <= '0;
      shamt_q  <= '0;
      op_q     <= OP_SLL;
      result_q <= '0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          rdy_q <= 1'b0;
          if (ctrl_shift) begin
            work_q  <= data_operandA;
            shamt_q <= ctrl_shiftamt;
            op_q    <= ctrl_op;
            k_q     <= K_FIRST;
            busy_q  <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          // New requests are ignored here; captured values stay stable
          work_q <= stage_out;
          if (k_q == 3'd0) begin
            result_q <= stage_out;
            rdy_q    <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StDone;
          end else begin
            k_q <= k_q - 3'd1;
          end
        end
        StDone: begin
          rdy_q <= 1'b0;
          if (ctrl_shift) begin
            // Back-to-back capture straight from the ready cycle
            work_q  <= data_operandA;
            shamt_q <= ctrl_shiftamt;
            op_q    <= ctrl_op;
            k_q     <= K_FIRST;
            busy_q  <= 1'b1;
            state_q <= StShift;
          end else begin
            state_q <= StIdle;
          end
        end
        default: begin
          rdy_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq: vector table plus back-to-back, ignore and reset sequences.
module tb_shift_unit_seq;

  logic        clock;
  logic        resetn;
  logic        ctrl_shift;
  logic        ctrl_op;
  logic [31:0] data_operandA;
  logic [4:0]  ctrl_shiftamt;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        busy;

  int checks;
  int failures;

  shift_unit_seq dut (
    .clock          (clock),
    .resetn         (resetn),
    .ctrl_shift     (ctrl_shift),
    .ctrl_op        (ctrl_op),
    .data_operandA  (data_operandA),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        op;
    logic [31:0] a;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive a request so that the next rising edge captures it, then scramble the inputs
  task automatic apply_op(input logic op, input logic [31:0] a, input logic [4:0] sh);
    @(negedge clock);
    ctrl_shift    = 1'b1;
    ctrl_op       = op;
    data_operandA = a;
    ctrl_shiftamt = sh;
    @(posedge clock);
    #1;
    ctrl_shift    = 1'b0;
    ctrl_op       = ~op;
    data_operandA = ~a;
    ctrl_shiftamt = ~sh;
  endtask

  // Count edges until the ready pulse is seen (bounded)
  task automatic wait_rdy(output int n);
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!data_resultRDY && n < 20);
  endtask

  int lat;
  int rdy_seen;

  initial begin
    checks        = 0;
    failures      = 0;
    resetn        = 1'b0;
    ctrl_shift    = 1'b0;
    ctrl_op       = 1'b0;
    data_operandA = '0;
    ctrl_shiftamt = '0;

    vecs[0]  = '{"sra_8000_by16",   1'b1, 32'h80000000, 5'd16, 32'hFFFF8000};
    vecs[1]  = '{"sll_1_by31",      1'b0, 32'h00000001, 5'd31, 32'h80000000};
    vecs[2]  = '{"sra_7fff_by31",   1'b1, 32'h7FFFFFFF, 5'd31, 32'h00000000};
    vecs[3]  = '{"sra_f000_by4",    1'b1, 32'hF0000000, 5'd4,  32'hFF000000};
    vecs[4]  = '{"sll_dead_by0",    1'b0, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF};
    vecs[5]  = '{"sra_dead_by0",    1'b1, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF};
    vecs[6]  = '{"sll_3_by2",       1'b0, 32'h00000003, 5'd2,  32'h0000000C};
    vecs[7]  = '{"sll_1234_by4",    1'b0, 32'h12345678, 5'd4,  32'h23456780};
    vecs[8]  = '{"sra_1234_by8",    1'b1, 32'h12345678, 5'd8,  32'h00123456};
    vecs[9]  = '{"sra_8001_by1",    1'b1, 32'h80000001, 5'd1,  32'hC0000000};
    vecs[10] = '{"sll_ffff_by5",    1'b0, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFE0};
    vecs[11] = '{"sra_8000_by31",   1'b1, 32'h80000000, 5'd31, 32'hFFFFFFFF};
    vecs[12] = '{"sll_a5a5_by13",   1'b0, 32'hA5A5A5A5, 5'd13, 32'hB4B4A000};
    vecs[13] = '{"sra_8765_by7",    1'b1, 32'h87654321, 5'd7,  32'hFF0ECA86};

    // Reset state
    #1;
    check("reset_result", data_result, 32'h0);
    check("reset_rdy", {31'h0, data_resultRDY}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 14; i++) begin
      apply_op(vecs[i].op, vecs[i].a, vecs[i].sh);
      check({vecs[i].name, "_busy"}, {31'h0, busy}, 32'h1);
      wait_rdy(lat);
      check({vecs[i].name, "_latency"}, 32'(lat), 32'd5);
      check({vecs[i].name, "_result"}, data_result, vecs[i].exp);
      @(posedge clock);
      #1;
      check({vecs[i].name, "_rdy_pulse"}, {31'h0, data_resultRDY}, 32'h0);
      check({vecs[i].name, "_hold"}, data_result, vecs[i].exp);
    end

    // Back-to-back: second request during the DONE cycle
    apply_op(1'b1, 32'h80000000, 5'd16);
    wait_rdy(lat);
    check("b2b_first_latency", 32'(lat), 32'd5);
    check("b2b_first_result", data_result, 32'hFFFF8000);
    ctrl_shift    = 1'b1;
    ctrl_op       = 1'b0;
    data_operandA = 32'h00000003;
    ctrl_shiftamt = 5'd2;
    @(posedge clock);
    #1;
    ctrl_shift    = 1'b0;
    data_operandA = 32'hFFFFFFFF;
    check("b2b_busy_after_done", {31'h0, busy}, 32'h1);
    check("b2b_rdy_low", {31'h0, data_resultRDY}, 32'h0);
    check("b2b_hold_first", data_result, 32'hFFFF8000);
    wait_rdy(lat);
    check("b2b_gap", 32'(lat + 1), 32'd6);
    check("b2b_second_result", data_result, 32'h0000000C);
    @(posedge clock);
    #1;

    // Request during SHIFT is ignored
    apply_op(1'b0, 32'h00000001, 5'd4);
    @(negedge clock);
    ctrl_shift    = 1'b1;
    ctrl_op       = 1'b1;
    data_operandA = 32'hFFFFFFFF;
    ctrl_shiftamt = 5'd31;
    @(posedge clock);
    #1;
    ctrl_shift = 1'b0;
    check("ign_busy", {31'h0, busy}, 32'h1);
    wait_rdy(lat);
    check("ign_latency", 32'(lat), 32'd4);
    check("ign_result", data_result, 32'h00000010);
    rdy_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY || busy) rdy_seen++;
    end
    check("ign_no_second_op", 32'(rdy_seen), 32'd0);

    // Reset during the third SHIFT cycle aborts the operation
    apply_op(1'b0, 32'h00000F0F, 5'd8);
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b0;
    #1;
    check("rst_mid_result", data_result, 32'h0);
    check("rst_mid_busy", {31'h0, busy}, 32'h0);
    check("rst_mid_rdy", {31'h0, data_resultRDY}, 32'h0);
    @(posedge clock);
    @(negedge clock);
    resetn   = 1'b1;
    rdy_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdy_seen++;
    end
    check("rst_no_rdy", 32'(rdy_seen), 32'd0);
    check("rst_result_stays0", data_result, 32'h0);
    apply_op(1'b1, 32'hF0000000, 5'd4);
    wait_rdy(lat);
    check("post_rst_latency", 32'(lat), 32'd5);
    check("post_rst_result", data_result, 32'hFF000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_unit_seq.md
SHIFT_UNIT_SEQ -- requirements
Module: shift_unit_seq

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 and shift amount width at 5.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 ctrl_shift  input  1  start request, sampled on the rising edge of clock.
REQ-005 ctrl_op  input  1  operation: 0 = logical left (SLL), 1 = arithmetic right (SRA).
REQ-006 data_operandA  input  32  value to shift; captured with ctrl_shift.
REQ-007 ctrl_shiftamt  input  5  shift amount 0..31; captured with ctrl_shift.
REQ-008 data_result  output  32  shifted result; registered.
REQ-009 data_resultRDY  output  1  one-cycle pulse: data_result is valid.
REQ-010 busy  output  1  high while an operation is in progress (SHIFT state).

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-012 IDLE: ctrl_shift=1 SHALL capture operand, shamt and op into internal registers, load stage index k=4, and go to SHIFT.
REQ-013 SHIFT: each cycle SHALL shift the working register by 2^k when shamt[k]=1, else hold it; k then decrements.
REQ-014 Stages SHALL be applied in order 16, 8, 4, 2, 1 (k=4..0), for exactly 5 SHIFT cycles regardless of shamt.
REQ-015 After the k=0 cycle, the FSM SHALL go to DONE.
REQ-016 Latency: capture at edge E; data_result and data_resultRDY SHALL update at edge E+5; data_resultRDY SHALL be high for exactly one cycle.
REQ-017 SRA SHALL fill vacated high bits with the captured operand bit 31; SLL SHALL fill vacated low bits with 0.
REQ-018 shamt=0 SHALL return the captured operand unchanged, with the same 5-cycle latency.
REQ-019 ctrl_shift while in SHIFT SHALL be ignored; captured values SHALL not change and busy stays 1.
REQ-020 DONE: ctrl_shift=1 SHALL start a new capture and go to SHIFT (back-to-back); otherwise go to IDLE.
REQ-021 data_result SHALL hold its last value until the next completion; only the DONE entry updates it.
REQ-022 Input changes after the capture edge SHALL NOT affect the in-flight operation.
REQ-023 busy SHALL be 1 exactly in SHIFT; data_resultRDY SHALL be 1 exactly in DONE.

Reset
REQ-024 resetn=0 SHALL immediately force: state IDLE, k=0, data_result=0, data_resultRDY=0, busy=0, internal registers=0.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no data_resultRDY pulse.
REQ-026 After resetn deasserts, the first ctrl_shift SHALL be accepted normally.

Structure
REQ-027 The shared ALU package SHALL define OP_SLL=0, OP_SRA=1, the FSM state encodings (2-bit), DATA_W=32 and SHAMT_W=5.
REQ-028 One combinational sub-module, shift_stage, SHALL implement one variable-amount stage.
REQ-029 shift_stage inputs: data (32), op (1), k (3), enable (1). Output: data shifted by 2^k when enable=1, else passed through.
REQ-030 The top level SHALL contain the FSM, the stage counter, the capture registers and the result register.

Verification
REQ-031 SRA 0x80000000 by 16 -> data_result 0xFFFF8000; data_resultRDY at edge E+5 only.
REQ-032 SLL 0x00000001 by 31 -> 0x80000000; SRA 0x7FFFFFFF by 31 -> 0x00000000; SRA 0xF0000000 by 4 -> 0xFF000000.
REQ-033 shamt=0, operand 0xDEADBEEF, both ops -> 0xDEADBEEF after 5 cycles.
REQ-034 Back-to-back: second ctrl_shift in the DONE cycle (SLL 0x3 by 2) -> second data_resultRDY exactly 6 cycles after the first, result 0x0000000C.
REQ-035 ctrl_shift pulsed with different data during SHIFT -> ignored; first result unchanged.
REQ-036 resetn low at the third SHIFT cycle -> outputs 0 immediately, no data_resultRDY; a later request completes correctly.
